// File: rtl/mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_ctrl
// Brief    : Single-port word memory behind a fixed-latency request/response
//            handshake, with byte-enabled writes and out-of-range detection.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_ctrl #(
    parameter int    WIDTH        = 64,
    parameter int    ADDR_WIDTH   = 10,
    parameter int    LATENCY      = 2,
    parameter string INITIAL_FILE = ""
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cs,
    input  logic                 i_rw,
    input  logic [63:0]          i_addr,
    input  logic [WIDTH-1:0]     i_data,
    input  logic [WIDTH/8-1:0]   i_be,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_err
);

    localparam int c_NUM_BYTES = WIDTH / 8;
    localparam int c_DEPTH     = 2 ** ADDR_WIDTH;

    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_IDLE = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    // Only meaningful when LATENCY >= 2; WAIT spends this many extra cycles.
    localparam logic [2:0] c_WAIT_LOAD = 3'(LATENCY - 2);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [2:0]            r_cnt;
    logic [2:0]            w_next_cnt;
    logic                  r_rw;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_rdata;
    logic [WIDTH-1:0]      r_mem [c_DEPTH];

    logic                  w_accept;
    logic                  w_addr_oor;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;

    assign w_accept   = i_cs && (r_state == c_ST_IDLE);
    assign w_addr_oor = |i_addr[63:ADDR_WIDTH];
    assign w_wr_idx   = i_addr[ADDR_WIDTH-1:0];
    // Track the live address while idle so a LATENCY=1 read sees its word at
    // the accepting edge; afterwards follow the captured address.
    assign w_rd_idx   = (r_state == c_ST_IDLE) ? i_addr[ADDR_WIDTH-1:0] : r_addr;

    // ------------------------------------------------------------------
    // State register and request capture
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_ST_INIT;
            r_cnt   <= 3'd0;
            r_rw    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_rw   <= i_rw;
                r_err  <= w_addr_oor;
                r_addr <= i_addr[ADDR_WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            c_ST_INIT: begin
                w_next_state = c_ST_IDLE;
            end
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_next_state = c_ST_RESP;
                    end else begin
                        w_next_state = c_ST_WAIT;
                        w_next_cnt   = c_WAIT_LOAD;
                    end
                end
            end
            c_ST_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next_state = c_ST_RESP;
                end else begin
                    w_next_cnt = r_cnt - 3'd1;
                end
            end
            c_ST_RESP: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state so reset clears them without a clock
    // ------------------------------------------------------------------
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_data  = '0;
        o_err   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                o_ready = 1'b1;
            end
            c_ST_RESP: begin
                o_valid = 1'b1;
                o_err   = r_err;
                if (!r_rw && !r_err) begin
                    o_data = r_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: not reset, so contents survive i_rst_n
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_accept && i_rw && !w_addr_oor) begin
            for (int k = 0; k < c_NUM_BYTES; k++) begin
                if (i_be[k]) begin
                    r_mem[w_wr_idx][8*k +: 8] <= i_data[8*k +: 8];
                end
            end
        end
    end

    // Writes commit at accept and no second accept can occur before RESP,
    // so this registered read always observes the merged word.
    always_ff @(posedge i_clk) begin
        r_rdata <= r_mem[w_rd_idx];
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_ctrl
// Brief    : Self-checking bench for mem_port_ctrl against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_ctrl;

    localparam int LAT = 2;
    localparam int AW  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cs = 1'b0;
    logic        rw = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] data = '0;
    logic [7:0]  be = '0;
    logic        ready, valid, err;
    logic [63:0] rdata;

    logic        cs1 = 1'b0, cs7 = 1'b0;
    logic        ready1, valid1, err1, ready7, valid7, err7;
    logic [63:0] rdata1, rdata7;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] model [1024];

    always #5 clk = ~clk;

    mem_port_ctrl #(.WIDTH(64), .ADDR_WIDTH(AW), .LATENCY(LAT), .INITIAL_FILE("")) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs), .i_rw(rw), .i_addr(addr),
        .i_data(data), .i_be(be), .o_ready(ready), .o_valid(valid),
        .o_data(rdata), .o_err(err)
    );

    mem_port_ctrl #(.WIDTH(64), .ADDR_WIDTH(AW), .LATENCY(1), .INITIAL_FILE("")) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs1), .i_rw(rw), .i_addr(addr),
        .i_data(data), .i_be(be), .o_ready(ready1), .o_valid(valid1),
        .o_data(rdata1), .o_err(err1)
    );

    mem_port_ctrl #(.WIDTH(64), .ADDR_WIDTH(AW), .LATENCY(7), .INITIAL_FILE("")) dut7 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs7), .i_rw(rw), .i_addr(addr),
        .i_data(data), .i_be(be), .o_ready(ready7), .o_valid(valid7),
        .o_data(rdata7), .o_err(err7)
    );

    // Expected {err, data} of a request; updates the word array for writes.
    function automatic logic [64:0] model_req(input logic w, input logic [63:0] a,
                                              input logic [63:0] dt, input logic [7:0] b);
        if (a[63:AW] != '0) return {1'b1, 64'h0};
        if (w) begin
            for (int k = 0; k < 8; k++)
                if (b[k]) model[a[AW-1:0]][8*k +: 8] = dt[8*k +: 8];
            return 65'h0;
        end
        return {1'b0, model[a[AW-1:0]]};
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        if ($urandom_range(0, 3) == 0) begin
            a = {$urandom, $urandom};
            if (a[63:AW] == '0) a[AW] = 1'b1;
        end else begin
            a = 64'($urandom_range(0, 15));
        end
        return a;
    endfunction

    // Drives one request on the main DUT and reports what it observed.
    // lat counts the accepting edge as edge 1; post is {valid, ready} one
    // edge after the response; viol flags ready/err/data activity while busy.
    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] dt,
                         input logic [7:0] b, output int lat, output logic [63:0] d_o,
                         output logic e_o, output logic [1:0] post, output logic viol);
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        cs = 1'b1; rw = w; addr = a; data = dt; be = b;
        @(posedge clk); #1;
        cs = 1'b0; rw = 1'($urandom); addr = {$urandom, $urandom};
        data = {$urandom, $urandom}; be = 8'($urandom);
        lat = -1; d_o = '0; e_o = 1'b0; viol = 1'b0; post = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            if (valid === 1'b1) begin
                lat = k; d_o = rdata; e_o = err;
                break;
            end
            if (ready !== 1'b0 || err !== 1'b0 || rdata !== '0) viol = 1'b1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        post = {valid, ready};
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({ready, valid, err, rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_hold: rdy=%b vld=%b err=%b data=%h, expected all 0", ready, valid, err, rdata);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        tests_run++;
        if ({ready, valid, err, rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_release_init: rdy=%b vld=%b err=%b data=%h, expected all 0", ready, valid, err, rdata);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({ready, valid, err, rdata} !== {1'b1, 66'h0}) begin
            tests_failed++;
            $display("FAIL reset_first_edge: rdy=%b vld=%b err=%b data=%h, expected rdy=1 others 0", ready, valid, err, rdata);
        end
    endtask

    task automatic test_fill();
        int lat; logic [63:0] d, wd; logic e, v; logic [1:0] post; logic [64:0] exp;
        for (int i = 0; i < 32; i++) begin
            logic w = (i < 16);
            wd = {$urandom, $urandom};
            exp = model_req(w, 64'(i % 16), wd, 8'hFF);
            issue(w, 64'(i % 16), wd, 8'hFF, lat, d, e, post, v);
            tests_run++;
            if (lat != LAT || {e, d} !== exp || post !== 2'b01 || v) begin
                tests_failed++;
                $display("FAIL fill[%0d]: lat=%0d err=%b data=%h post=%b viol=%b, expected lat=%0d err=%b data=%h post=01 viol=0",
                         i, lat, e, d, post, v, LAT, exp[64], exp[63:0]);
            end
        end
    endtask

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  b;
        logic        xe;
        logic [63:0] xd;
    } op_t;

    task automatic test_directed();
        op_t ops[10];
        int lat; logic [63:0] d; logic e, v; logic [1:0] post; logic [64:0] unused_r;
        ops[0] = '{1'b1, 64'd5,     64'h1122334455667788, 8'hFF, 1'b0, 64'h0};
        ops[1] = '{1'b0, 64'd5,     64'h0,                8'h00, 1'b0, 64'h1122334455667788};
        ops[2] = '{1'b1, 64'd5,     64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 64'h0};
        ops[3] = '{1'b0, 64'd5,     64'h0,                8'hA5, 1'b0, 64'h11223344AAAAAAAA};
        ops[4] = '{1'b0, 64'h400,   64'h0,                8'hFF, 1'b1, 64'h0};
        ops[5] = '{1'b1, 64'h400,   64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1, 64'h0};
        ops[6] = '{1'b0, 64'd0,     64'h0,                8'h00, 1'b0, model[0]};
        ops[7] = '{1'b1, 64'd3,     64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0, 64'h0};
        ops[8] = '{1'b0, 64'd3,     64'h0,                8'h00, 1'b0, model[3]};
        ops[9] = '{1'b0, {1'b1, 63'd5}, 64'h0,            8'hFF, 1'b1, 64'h0};
        for (int i = 0; i < 10; i++) begin
            unused_r = model_req(ops[i].w, ops[i].a, ops[i].d, ops[i].b);
            issue(ops[i].w, ops[i].a, ops[i].d, ops[i].b, lat, d, e, post, v);
            tests_run++;
            if (lat != LAT || e !== ops[i].xe || d !== ops[i].xd || post !== 2'b01 || v) begin
                tests_failed++;
                $display("FAIL directed[%0d]: lat=%0d err=%b data=%h post=%b viol=%b, expected lat=%0d err=%b data=%h post=01 viol=0",
                         i, lat, e, d, post, v, LAT, ops[i].xe, ops[i].xd);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [63:0] d, a, wd; logic e, v, w; logic [7:0] b;
        logic [1:0] post; logic [64:0] exp;
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom); a = rand_addr(); wd = {$urandom, $urandom}; b = 8'($urandom);
            exp = model_req(w, a, wd, b);
            issue(w, a, wd, b, lat, d, e, post, v);
            tests_run++;
            if (lat != LAT || {e, d} !== exp || post !== 2'b01 || v) begin
                tests_failed++;
                $display("FAIL random[%0d] w=%b a=%h: lat=%0d err=%b data=%h post=%b viol=%b, expected lat=%0d err=%b data=%h",
                         i, w, a, lat, e, d, post, v, LAT, exp[64], exp[63:0]);
            end
        end
    endtask

    // cs held high with new write data every cycle: only every (LAT+1)-th
    // edge accepts, and only that edge's data lands in storage.
    task automatic test_back_to_back();
        int lat, n = 0, p; logic [63:0] d; logic e, v; logic [1:0] post; logic [64:0] exp;
        @(negedge clk);
        while (ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        cs = 1'b1; rw = 1'b1; addr = 64'd9;
        for (int t = 0; t < 12; t++) begin
            data = {$urandom, $urandom}; be = 8'($urandom);
            if (t % (LAT + 1) == 0) exp = model_req(1'b1, 64'd9, data, be);
            @(posedge clk); #1;
            p = t % (LAT + 1);
            tests_run++;
            if ({ready, valid} !== {p == LAT, p == LAT - 1}) begin
                tests_failed++;
                $display("FAIL b2b_cycle[%0d]: rdy=%b vld=%b, expected rdy=%b vld=%b",
                         t, ready, valid, p == LAT, p == LAT - 1);
            end
            @(negedge clk);
        end
        cs = 1'b0;
        exp = model_req(1'b0, 64'd9, 64'h0, 8'h00);
        issue(1'b0, 64'd9, 64'h0, 8'h00, lat, d, e, post, v);
        tests_run++;
        if (lat != LAT || {e, d} !== exp || post !== 2'b01 || v) begin
            tests_failed++;
            $display("FAIL b2b_readback: lat=%0d err=%b data=%h, expected lat=%0d err=%b data=%h",
                     lat, e, d, LAT, exp[64], exp[63:0]);
        end
    endtask

    task automatic test_latency_builds();
        int p1, p7;
        @(negedge clk);
        rw = 1'b0; addr = 64'd2; cs1 = 1'b1; cs7 = 1'b1;
        for (int t = 0; t < 24; t++) begin
            @(posedge clk); #1;
            p1 = t % 2;
            p7 = t % 8;
            tests_run++;
            if ({ready1, valid1} !== {p1 == 1, p1 == 0}) begin
                tests_failed++;
                $display("FAIL lat1_cycle[%0d]: rdy=%b vld=%b, expected rdy=%b vld=%b",
                         t, ready1, valid1, p1 == 1, p1 == 0);
            end
            tests_run++;
            if ({ready7, valid7} !== {p7 == 7, p7 == 6}) begin
                tests_failed++;
                $display("FAIL lat7_cycle[%0d]: rdy=%b vld=%b, expected rdy=%b vld=%b",
                         t, ready7, valid7, p7 == 7, p7 == 6);
            end
        end
        @(negedge clk);
        cs1 = 1'b0; cs7 = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] d, wd; logic e, v; logic [1:0] post; logic [64:0] exp;
        // reset while a read waits
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = 64'd7; be = 8'h00;
        @(posedge clk); #1; cs = 1'b0;
        #2 rst_n = 1'b0; #1;
        tests_run++;
        if ({ready, valid, err, rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_in_wait: rdy=%b vld=%b err=%b data=%h, expected all 0", ready, valid, err, rdata);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({ready, valid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_no_resp[%0d]: rdy=%b vld=%b, expected 0 0", k, ready, valid);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        exp = model_req(1'b0, 64'd7, 64'h0, 8'h00);
        issue(1'b0, 64'd7, 64'h0, 8'h00, lat, d, e, post, v);
        tests_run++;
        if (lat != LAT || {e, d} !== exp) begin
            tests_failed++;
            $display("FAIL reset_persist_read: lat=%0d err=%b data=%h, expected lat=%0d err=%b data=%h",
                     lat, e, d, LAT, exp[64], exp[63:0]);
        end
        // reset while the response is on the outputs
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = 64'd7;
        @(posedge clk); #1; cs = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({valid, err, rdata} !== {1'b1, exp[64:0]}) begin
            tests_failed++;
            $display("FAIL resp_before_reset: vld=%b err=%b data=%h, expected vld=1 err=%b data=%h",
                     valid, err, rdata, exp[64], exp[63:0]);
        end
        #2 rst_n = 1'b0; #1;
        tests_run++;
        if ({ready, valid, err, rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_in_resp: rdy=%b vld=%b err=%b data=%h, expected all 0", ready, valid, err, rdata);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        // reset after a write was accepted: the write stays committed
        wd = {$urandom, $urandom};
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = 64'd8; data = wd; be = 8'hFF;
        exp = model_req(1'b1, 64'd8, wd, 8'hFF);
        @(posedge clk); #1; cs = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 64'd8, 64'h0, 8'h00, lat, d, e, post, v);
        tests_run++;
        if (lat != LAT || e !== 1'b0 || d !== wd) begin
            tests_failed++;
            $display("FAIL reset_committed_write: lat=%0d err=%b data=%h, expected lat=%0d err=0 data=%h",
                     lat, e, d, LAT, wd);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_random();
        test_back_to_back();
        test_latency_builds();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
